// File: rtl/edge_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_rd_pkg                                                           |
// | Shared sizes and state encoding for the edge accumulator readout.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package edge_rd_pkg;
    localparam int NWORD = 64;
    localparam int IDXW  = 6;
    localparam int CNTW  = 12;
    localparam int POPW  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage
`default_nettype wire

// File: rtl/edge_result_reader_popcount32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | popcount32                                                            |
// | Combinational count of set bits in a 32-bit word.                     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module popcount32
    import edge_rd_pkg::*;
(
    input  logic [31:0]     data_i,
    output logic [POPW-1:0] count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < 32; i++) begin
            count_o = count_o + POPW'(data_i[i]);
        end
    end
endmodule
`default_nettype wire

// File: rtl/edge_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_result_reader                                                    |
// | Walks all 64 accumulator words, streams them out, counts set bits.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module edge_result_reader
    import edge_rd_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            start,
    output logic [1:0]      sel1,
    output logic [7:0]      sel2,
    input  logic [31:0]     result_imp,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [31:0]     m_data,
    output logic [IDXW-1:0] m_index,
    output logic            m_last,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] edge_count
);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORD - 1);

    state_e          state_q;
    logic [IDXW-1:0] index_q;
    logic            m_valid_q;
    logic [31:0]     m_data_q;
    logic [IDXW-1:0] m_index_q;
    logic            m_last_q;
    logic            done_q;
    logic [CNTW-1:0] edge_count_q;

    logic [POPW-1:0] pop_cnt;
    logic            last_word;
    logic            skip_word;

    popcount32 u_pop (
        .data_i  (result_imp),
        .count_o (pop_cnt)
    );

    assign last_word = (index_q == LAST_IDX);
    assign skip_word = SKIP_ZERO && (result_imp == '0) && !last_word;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_index_q    <= '0;
            m_last_q     <= 1'b0;
            done_q       <= 1'b0;
            edge_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= SEL;
                        index_q      <= '0;
                        edge_count_q <= '0;
                    end
                end
                SEL: begin
                    edge_count_q <= edge_count_q + CNTW'(pop_cnt);
                    if (skip_word) begin
                        index_q <= index_q + IDXW'(1);
                    end else begin
                        m_data_q  <= result_imp;
                        m_index_q <= index_q;
                        m_last_q  <= last_word;
                        m_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (last_word) begin
                            // Park the index at 0 so the selects idle at zero.
                            index_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            index_q <= index_q + IDXW'(1);
                            state_q <= SEL;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel1       = index_q[5:4];
    assign sel2       = {4'b0000, index_q[3:0]};
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_index    = m_index_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign edge_count = edge_count_q;
endmodule
`default_nettype wire

// File: tb/tb_edge_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_edge_result_reader                                                 |
// | Directed bench for both SKIP_ZERO settings against a word-list model. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_edge_result_reader;
    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    logic start = 1'b0;
    logic m_ready = 1'b1;
    always #5 CLK = ~CLK;

    logic [31:0] mem [0:63];

    logic [1:0]  sel1_0, sel1_1;
    logic [7:0]  sel2_0, sel2_1;
    logic [31:0] res0, res1, md0, md1;
    logic        mv0, mv1, ml0, ml1, busy0, busy1, done0, done1;
    logic [5:0]  mi0, mi1;
    logic [11:0] ec0, ec1;

    assign res0 = mem[{sel1_0, sel2_0[3:0]}];
    assign res1 = mem[{sel1_1, sel2_1[3:0]}];

    edge_result_reader #(.SKIP_ZERO(1'b0)) u_dut0 (
        .CLK(CLK), .RST_n(RST_n), .start(start), .sel1(sel1_0), .sel2(sel2_0),
        .result_imp(res0), .m_valid(mv0), .m_ready(m_ready), .m_data(md0),
        .m_index(mi0), .m_last(ml0), .busy(busy0), .done(done0), .edge_count(ec0)
    );
    edge_result_reader #(.SKIP_ZERO(1'b1)) u_dut1 (
        .CLK(CLK), .RST_n(RST_n), .start(start), .sel1(sel1_1), .sel2(sel2_1),
        .result_imp(res1), .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
        .m_index(mi1), .m_last(ml1), .busy(busy1), .done(done1), .edge_count(ec1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [37:0] exp0[$];
    logic [37:0] exp1[$];
    int          exp_ec;
    int          emit [2];
    int          dcnt [2];
    logic        pst  [2];
    logic [31:0] pmd  [2];
    logic [5:0]  pmi  [2];
    logic        pml  [2];
    logic        pdone[2];
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Expected stream: every word for SKIP_ZERO=0; non-zero words plus word 63 otherwise.
    task automatic build_model();
        exp0.delete();
        exp1.delete();
        exp_ec = 0;
        for (int i = 0; i < 64; i++) begin
            exp_ec += $countones(mem[i]);
            exp0.push_back({6'(i), mem[i]});
            if (mem[i] != 32'h0 || i == 63) exp1.push_back({6'(i), mem[i]});
        end
    endtask

    task automatic mon(input int d, input logic mv, input logic [31:0] md, input logic [5:0] mi,
                       input logic ml, input logic bz, input logic dn, input logic [1:0] s1,
                       input logic [7:0] s2, input logic [11:0] ec);
        logic [37:0] e;
        string       p;
        int          qs;
        p  = (d == 0) ? "d0" : "d1";
        qs = (d == 0) ? exp0.size() : exp1.size();
        chk({p, "_sel2_hi"}, 64'(s2[7:4]), 64'd0);
        if (!bz) chk({p, "_idle_sel"}, 64'({s1, s2}), 64'd0);
        if (ml) chk({p, "_last_without_valid"}, 64'(mv), 64'd1);
        if (mv) chk({p, "_sel_vs_index"}, 64'({s1, s2[3:0]}), 64'(mi));
        if (pst[d]) begin
            chk({p, "_stall_valid"}, 64'(mv), 64'd1);
            chk({p, "_stall_data"},  64'(md), 64'(pmd[d]));
            chk({p, "_stall_index"}, 64'(mi), 64'(pmi[d]));
            chk({p, "_stall_last"},  64'(ml), 64'(pml[d]));
        end
        if (mv && m_ready) begin
            emit[d]++;
            if (qs == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_extra_word: actual index=%0d required=no word", p, mi);
            end else begin
                if (d == 0) e = exp0.pop_front();
                else        e = exp1.pop_front();
                chk({p, "_word_index"}, 64'(mi), 64'(e[37:32]));
                chk({p, "_word_data"},  64'(md), 64'(e[31:0]));
                chk({p, "_word_last"},  64'(ml), 64'(e[37:32] == 6'd63));
            end
        end
        if (dn) begin
            dcnt[d]++;
            chk({p, "_done_edge_count"}, 64'(ec), 64'(exp_ec));
            chk({p, "_done_words_left"}, 64'(qs), 64'd0);
            chk({p, "_done_single_cycle"}, 64'(pdone[d]), 64'd0);
        end
        pst[d]   = mv && !m_ready;
        pmd[d]   = md;
        pmi[d]   = mi;
        pml[d]   = ml;
        pdone[d] = dn;
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            mon(0, mv0, md0, mi0, ml0, busy0, done0, sel1_0, sel2_0, ec0);
            mon(1, mv1, md1, mi1, ml1, busy1, done1, sel1_1, sel2_1, ec1);
        end
    end

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, 64'(mv0),   64'd0);
        chk({nm, "_data"},  64'(md0),   64'd0);
        chk({nm, "_index"}, 64'(mi0),   64'd0);
        chk({nm, "_last"},  64'(ml0),   64'd0);
        chk({nm, "_busy"},  64'(busy0), 64'd0);
        chk({nm, "_done"},  64'(done0), 64'd0);
        chk({nm, "_count"}, 64'(ec0),   64'd0);
        chk({nm, "_sel"},   64'({sel1_0, sel2_0}), 64'd0);
        chk({nm, "_d1_valid"}, 64'(mv1), 64'd0);
        chk({nm, "_d1_busy"},  64'(busy1), 64'd0);
        chk({nm, "_d1_count"}, 64'(ec1), 64'd0);
    endtask

    // Negative x* arguments mean "no hand-computed expectation for this pass".
    task automatic run_pass(input string nm, input bit hold, input int stall_idx, input int stall_len,
                            input int rst_at, input int xlat0, input int xlat1, input int xec,
                            input int xem0, input int xem1);
        int lat0, lat1, stall_left;
        bit aborted;
        build_model();
        for (int d = 0; d < 2; d++) begin
            emit[d] = 0; dcnt[d] = 0; pst[d] = 1'b0; pdone[d] = 1'b0;
        end
        lat0 = -1; lat1 = -1; stall_left = stall_len; aborted = 1'b0;
        @(posedge CLK); #1;
        start = 1'b1; m_ready = 1'b1; mon_en = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge CLK); #1;
            if (!hold) start = 1'b0;
            if (done0 && lat0 < 0) lat0 = c;
            if (done1 && lat1 < 0) lat1 = c;
            if (hold && done0) start = 1'b0;
            if (stall_left > 0 && mv0 && mi0 == 6'(stall_idx)) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
            end
            if (rst_at >= 0 && mv0 && mi0 == 6'(rst_at)) begin
                mon_en = 1'b0;
                RST_n = 1'b0;
                #1;
                check_reset_outputs({nm, "_async_rst"});
                RST_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        m_ready = 1'b1;
        if (aborted) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK); #1;
                chk({nm, "_no_done0_after_rst"}, 64'(done0), 64'd0);
                chk({nm, "_no_busy0_after_rst"}, 64'(busy0), 64'd0);
            end
            chk({nm, "_no_done1_after_rst"}, 64'(done1), 64'd0);
        end else begin
            @(negedge CLK); #1;
            chk({nm, "_done0_seen"}, 64'(lat0 >= 0), 64'd1);
            chk({nm, "_done1_seen"}, 64'(lat1 >= 0), 64'd1);
            if (xlat0 >= 0) chk({nm, "_latency0"}, 64'(lat0), 64'(xlat0));
            if (xlat1 >= 0) chk({nm, "_latency1"}, 64'(lat1), 64'(xlat1));
            if (xec >= 0) begin
                chk({nm, "_count0_lit"}, 64'(ec0), 64'(xec));
                chk({nm, "_count1_lit"}, 64'(ec1), 64'(xec));
            end
            if (xem0 >= 0) chk({nm, "_emits0_lit"}, 64'(emit[0]), 64'(xem0));
            if (xem1 >= 0) chk({nm, "_emits1_lit"}, 64'(emit[1]), 64'(xem1));
            for (int k = 0; k < 5; k++) begin
                @(posedge CLK); #1;
            end
            chk({nm, "_idle0"}, 64'(busy0), 64'd0);
            chk({nm, "_idle1"}, 64'(busy1), 64'd0);
            chk({nm, "_count0_held"}, 64'(ec0), 64'(exp_ec));
            chk({nm, "_count1_held"}, 64'(ec1), 64'(exp_ec));
            chk({nm, "_one_done0"}, 64'(dcnt[0]), 64'd1);
            chk({nm, "_one_done1"}, 64'(dcnt[1]), 64'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST_n = 1'b1;
        repeat (2) @(posedge CLK);

        run_pass("allzero", 1'b0, -1, 0, -1, 129, 66, 0, 64, 1);

        mem[5] = 32'h8000_0001;
        run_pass("word5", 1'b0, -1, 0, -1, 129, 67, 2, 64, 2);

        for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
        run_pass("allones", 1'b0, -1, 0, -1, 129, 129, 2048, 64, 64);

        for (int i = 0; i < 64; i++)
            mem[i] = (i % 3 == 0) ? 32'h0 : 32'(32'h9E37_79B9 * 32'(i + 1));
        run_pass("stall10", 1'b0, 10, 7, -1, 136, -1, -1, 64, -1);
        run_pass("rst30", 1'b0, -1, 0, 30, -1, -1, -1, -1, -1);
        run_pass("after_rst", 1'b0, -1, 0, -1, 129, -1, -1, 64, -1);

        for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
        run_pass("held_start", 1'b1, -1, 0, -1, 129, 129, 2048, 64, 64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/edge_result_reader.md
EDGE_RESULT_READER -- requirements
Module: edge_result_reader

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 0; when 1, all-zero words other than index 63 are not emitted.
REQ-002 SHALL have port CLK  input  1  single clock; all state is updated on its rising edge.
REQ-003 SHALL have port RST_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  begins one full readout pass when sampled high in IDLE.
REQ-005 SHALL have port sel1  output  2  bank select to the edge accumulator, equal to word index bits [5:4].
REQ-006 SHALL have port sel2  output  8  word select to the edge accumulator; bits [3:0] = index bits [3:0], bits [7:4] = 0.
REQ-007 SHALL have port result_imp  input  32  combinational word returned by the accumulator for the current sel1/sel2.
REQ-008 SHALL have port m_valid  output  1  output word valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port m_data  output  32  captured accumulator word.
REQ-011 SHALL have port m_index  output  6  word index of m_data (0..63, bit offset = 32*index).
REQ-012 SHALL have port m_last  output  1  high with m_valid when m_index == 63.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-015 SHALL have port edge_count  output  12  total set bits over all 64 words sampled in the pass.

Function
REQ-016 SHALL implement FSM states IDLE, SEL, OUT, DONE.
REQ-017 IDLE: sel1/sel2 held at 0; on start=1 -> SEL, index=0, edge_count cleared.
REQ-018 SEL: result_imp is sampled at the end of this single cycle; popcount(result_imp) is added to edge_count.
REQ-019 SEL, word emitted: m_data<=result_imp, m_index<=index, m_valid<=1, next state OUT.
REQ-020 SEL with SKIP_ZERO=1, result_imp==0 and index!=63: no emission; index+1, sel updated, remain in SEL; one cycle per skipped word.
REQ-021 OUT: m_data/m_index/m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 OUT, handshake (m_valid&m_ready) with index<63: m_valid<=0, index+1, sel updated, -> SEL.
REQ-023 OUT, handshake with index==63: m_valid<=0, -> DONE.
REQ-024 DONE: done=1 for exactly one cycle, edge_count final and held until the next start; -> IDLE.
REQ-025 Throughput with m_ready tied high: one word per 2 cycles; full pass = 1+128 cycles from start to done.
REQ-026 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-027 edge_count SHALL not saturate or wrap; maximum value is 2048.
REQ-028 sel1/sel2 SHALL be registered outputs with no combinational path from result_imp or m_ready.

Reset
REQ-029 On RST_n=0 the block SHALL asynchronously enter IDLE with index=0, sel1=0, sel2=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0, edge_count=0.
REQ-030 Reset asserted mid-pass SHALL abandon the pass with no done pulse; the next start restarts from index 0.

Structure
REQ-031 Shared package edge_rd_pkg SHALL hold the state enum, NWORD=64, IDXW=6, CNTW=12.
REQ-032 A sub-module popcount32 (32-bit in, 6-bit count out, combinational) SHALL compute per-word bit counts.

Verification
REQ-033 All-zero accumulator, SKIP_ZERO=0, m_ready=1, start -> 64 words with m_data=0 and indices 0..63 in order; m_last only on index 63; done 129 cycles after start; edge_count=0.
REQ-034 Word 5 = 0x8000_0001, all others 0, SKIP_ZERO=1 -> exactly two emissions: (index 5, 0x8000_0001) and (index 63, 0, m_last=1); edge_count=2.
REQ-035 All ones, SKIP_ZERO=0 -> edge_count=2048 at done; sel1/sel2 step through (0,0)..(3,15) in order.
REQ-036 m_ready low for 7 cycles while index 10 is valid -> m_data/m_index stable, no sel change, no drops or duplicates.
REQ-037 RST_n pulsed low at index 30 -> outputs reach reset values immediately with no done pulse; the next start begins at index 0 with edge_count=0.
REQ-038 start held high for a whole pass -> exactly one pass and one done pulse; the held start SHALL not relaunch until IDLE.
